// File: rtl/enable_edge_qualifier.sv
// Synchronises a raw enable level, qualifies it as stable-high and emits one pulse per edge.
// Optional pulse counter (clr_count/pulse_count) is built when EDGE_QUAL_COUNT_EN is defined.
module enable_edge_qualifier #(
  parameter int unsigned STABLE_CYCLES  = 3,
  parameter int unsigned HOLDOFF_CYCLES = 5,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_raw,
  output logic             enable_pulse,
`ifdef EDGE_QUAL_COUNT_EN
  input  logic             clr_count,
  output logic [CNT_W-1:0] pulse_count,
`endif
  output logic             busy
);

  localparam int unsigned QW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HW = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [QW-1:0] QualLast = QW'((STABLE_CYCLES == 0) ? 0 : STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HoldLast = HW'((HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1);

  if (STABLE_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("enable_edge_qualifier: STABLE_CYCLES and CNT_W must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StQual,
    StFire,
    StHold,
    StWaitLow
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, en_s_q;
  logic [QW-1:0]   qual_cnt_q, qual_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            pulse_q, pulse_d;
  logic            busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      en_s_q     <= 1'b0;
      state_q    <= StIdle;
      qual_cnt_q <= '0;
      hold_cnt_q <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= enable_raw;
      en_s_q     <= sync1_q;
      state_q    <= state_d;
      qual_cnt_q <= qual_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    qual_cnt_d = qual_cnt_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (en_s_q) begin
          // The IDLE sample counts as the first stable sample.
          qual_cnt_d = QW'(1);
          state_d    = (STABLE_CYCLES == 1) ? StFire : StQual;
        end
      end
      StQual: begin
        if (!en_s_q) begin
          qual_cnt_d = '0;
          state_d    = StIdle;
        end else if (qual_cnt_q == QualLast) begin
          state_d = StFire;
        end else begin
          qual_cnt_d = qual_cnt_q + 1'b1;
        end
      end
      StFire: begin
        qual_cnt_d = '0;
        hold_cnt_d = '0;
        state_d    = (HOLDOFF_CYCLES == 0) ? StWaitLow : StHold;
      end
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d = StWaitLow;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StWaitLow: begin
        if (!en_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered copies of the next-state decode, so they track state_q exactly.
  always_comb begin
    pulse_d = (state_d == StFire);
    busy_d  = (state_d != StIdle);
  end

  assign enable_pulse = pulse_q;
  assign busy         = busy_q;

`ifdef EDGE_QUAL_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_count) begin
      count_d = '0;
    end else if (pulse_q && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign pulse_count = count_q;
`endif

endmodule
